ccr_unit: RTL and testbench
===========================

CCR_UNIT -- requirements
Module: ccr_unit

Interface
REQ-001 Parameter bits, default 16, width of the DBcc loop counter.
REQ-002 clk  input  1  rising-edge clock; sole clock.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-004 flag_we  input  1  latch ALU flags into CCR this edge.
REQ-005 flag_mask  input  5  per-flag update enable {X,N,Z,V,C}; 0 = hold that bit.
REQ-006 c, z, v, n  input  1 each  ALU carry, zero, overflow, negative flags.
REQ-007 ccr_load  input  1  direct CCR write (MOVE to CCR).
REQ-008 ccr_in  input  5  value for direct write, {X,N,Z,V,C}.
REQ-009 ccr  output  5  registered CCR, {X,N,Z,V,C}.
REQ-010 cond_req  input  1  condition-evaluation request, one per asserted cycle.
REQ-011 cond  input  4  68000 condition code.
REQ-012 dbcc  input  1  request is DBcc: apply loop-counter semantics.
REQ-013 count_in  input  bits  DBcc counter operand.
REQ-014 cond_ack  output  1  result valid, one-cycle pulse per request.
REQ-015 taken  output  1  branch decision.
REQ-016 count_out  output  bits  DBcc counter result.

Function
REQ-017 The CCR update shall have priority reset > ccr_load > flag_we; with ccr_load and flag_we both high, ccr shall equal ccr_in next cycle.
REQ-018 On flag_we, each CCR bit with its mask bit set shall take the corresponding ALU flag; X shall take c; unmasked bits shall hold.
REQ-019 ccr shall change exactly one cycle after the qualifying edge; no combinational path from inputs to ccr.
REQ-020 A request sampled with cond_req=1 shall produce cond_ack=1, taken and count_out on the next cycle; cond_ack shall be 0 otherwise.
REQ-021 Back-to-back requests shall be accepted every cycle with no stall; there is no busy signal.
REQ-022 Evaluation shall use the ccr value registered before the request edge; a same-edge flag_we or ccr_load shall not affect that request.
REQ-023 Conditions (0-F): T 1; F 0; HI !C&!Z; LS C|Z; CC !C; CS C; NE !Z; EQ Z; VC !V; VS V; PL !N; MI N; GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V).
REQ-024 With dbcc=0: taken = condition result; count_out = count_in.
REQ-025 With dbcc=1 and condition true: taken=0, count_out=count_in.
REQ-026 With dbcc=1 and condition false: count_out=count_in-1 mod 2^bits; taken=1 unless count_in=0, then taken=0 and count_out=all-ones.
REQ-027 taken and count_out shall hold their last values while cond_ack=0.

Reset
REQ-028 On reset: ccr=0, cond_ack=0, taken=0, count_out=0 on the next edge.
REQ-029 A request on the reset edge shall be discarded; no cond_ack shall follow.
REQ-030 A pending result (cond_ack due next cycle) shall be suppressed when reset is asserted on that edge.

Verification
REQ-031 Reset, then flag_we, mask 11111, c=1 z=0 v=0 n=1 -> ccr=5'b11001 one cycle later.
REQ-032 ccr=5'b01000 (N=1,V=0), cond_req cond=D (LT) dbcc=0 -> cond_ack=1, taken=1 next cycle; cond=C (GE) -> taken=0.
REQ-033 dbcc=1, cond=1 (F), count_in=0005 -> count_out=0004, taken=1; count_in=0000 -> count_out=FFFF, taken=0.
REQ-034 dbcc=1, cond=7 (EQ) with Z=1, count_in=0003 -> taken=0, count_out=0003.
REQ-035 ccr_load ccr_in=5'b00100 with flag_we mask 11111 same edge -> ccr=5'b00100; same-edge cond=7 (EQ) evaluates the prior ccr.
REQ-036 Mask 00010 flag_we with v=1 from ccr=0 -> ccr=5'b00010; reset during cond_req -> cond_ack stays 0, ccr=0.

Source files
------------

// File: rtl/ccr_unit.sv
// ccr_unit: 68000-style condition code register with condition evaluation
// and DBcc loop-counter handling.
//
// The CCR holds {X,N,Z,V,C}. It is written either directly (ccr_load) or
// from the ALU flags under a per-bit mask (flag_we). Each cycle a condition
// request may be issued; the result appears one cycle later, evaluated
// against the CCR value that was registered before the request edge.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous active-high reset
//   flag_we    latch ALU flags into CCR under flag_mask
//   flag_mask  per-flag update enable {X,N,Z,V,C}
//   c,z,v,n    ALU carry, zero, overflow, negative
//   ccr_load   direct CCR write, takes priority over flag_we
//   ccr_in     direct CCR write value {X,N,Z,V,C}
//   ccr        registered CCR {X,N,Z,V,C}
//   cond_req   condition-evaluation request
//   cond       68000 condition code (0..F)
//   dbcc       apply DBcc loop-counter semantics
//   count_in   DBcc counter operand
//   cond_ack   one-cycle result-valid pulse
//   taken      branch decision (held between results)
//   count_out  DBcc counter result (held between results)
module ccr_unit #(
  parameter int bits = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flag_we,
  input  logic [4:0]      flag_mask,
  input  logic            c,
  input  logic            z,
  input  logic            v,
  input  logic            n,
  input  logic            ccr_load,
  input  logic [4:0]      ccr_in,
  output logic [4:0]      ccr,
  input  logic            cond_req,
  input  logic [3:0]      cond,
  input  logic            dbcc,
  input  logic [bits-1:0] count_in,
  output logic            cond_ack,
  output logic            taken,
  output logic [bits-1:0] count_out
);

  // CCR bit positions
  localparam int XB = 4;
  localparam int NB = 3;
  localparam int ZB = 2;
  localparam int VB = 1;
  localparam int CB = 0;

  // 68000 condition table evaluated against a CCR snapshot.
  function automatic logic eval_cond(input logic [3:0] cc, input logic [4:0] f);
    logic fn, fz, fv, fc;
    logic res;
    fn = f[NB];
    fz = f[ZB];
    fv = f[VB];
    fc = f[CB];
    case (cc)
      4'h0: res = 1'b1;
      4'h1: res = 1'b0;
      4'h2: res = ~fc & ~fz;
      4'h3: res = fc | fz;
      4'h4: res = ~fc;
      4'h5: res = fc;
      4'h6: res = ~fz;
      4'h7: res = fz;
      4'h8: res = ~fv;
      4'h9: res = fv;
      4'hA: res = ~fn;
      4'hB: res = fn;
      4'hC: res = (fn == fv);
      4'hD: res = (fn != fv);
      4'hE: res = ~fz & (fn == fv);
      default: res = fz | (fn != fv);
    endcase
    return res;
  endfunction

  // Counter decrement wraps modulo 2^bits; zero wraps to all-ones.
  function automatic logic [bits-1:0] dec_wrap(input logic [bits-1:0] x);
    return x - {{(bits-1){1'b0}}, 1'b1};
  endfunction

  // X mirrors the carry, so the ALU flag vector carries c twice.
  logic [4:0] alu_flags;
  logic [4:0] ccr_flag_next;
  logic       cond_true_p0;
  logic       taken_p0;
  logic [bits-1:0] count_p0;

  assign alu_flags     = {c, n, z, v, c};
  assign ccr_flag_next = (alu_flags & flag_mask) | (ccr & ~flag_mask);

  // Stage p0: combinational evaluation against the pre-edge CCR
  always_comb begin
    cond_true_p0 = eval_cond(cond, ccr);
    taken_p0     = cond_true_p0;
    count_p0     = count_in;
    if (dbcc) begin
      if (cond_true_p0) begin
        taken_p0 = 1'b0;
        count_p0 = count_in;
      end else begin
        count_p0 = dec_wrap(count_in);
        taken_p0 = (count_in != '0);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ccr <= '0;
    end else if (ccr_load) begin
      ccr <= ccr_in;
    end else if (flag_we) begin
      ccr <= ccr_flag_next;
    end
  end

  // Stage p1: registered result; taken/count_out hold between requests
  always_ff @(posedge clk) begin
    if (reset) begin
      cond_ack  <= 1'b0;
      taken     <= 1'b0;
      count_out <= '0;
    end else begin
      cond_ack <= cond_req;
      if (cond_req) begin
        taken     <= taken_p0;
        count_out <= count_p0;
      end
    end
  end

endmodule

// File: tb/tb_ccr_unit.sv
module tb_ccr_unit;

  localparam int BITS = 16;

  logic            clk = 1'b0;
  logic            reset;
  logic            flag_we;
  logic [4:0]      flag_mask;
  logic            c, z, v, n;
  logic            ccr_load;
  logic [4:0]      ccr_in;
  logic [4:0]      ccr;
  logic            cond_req;
  logic [3:0]      cond;
  logic            dbcc;
  logic [BITS-1:0] count_in;
  logic            cond_ack;
  logic            taken;
  logic [BITS-1:0] count_out;

  ccr_unit #(.bits(BITS)) dut (
    .clk(clk), .reset(reset), .flag_we(flag_we), .flag_mask(flag_mask),
    .c(c), .z(z), .v(v), .n(n), .ccr_load(ccr_load), .ccr_in(ccr_in),
    .ccr(ccr), .cond_req(cond_req), .cond(cond), .dbcc(dbcc),
    .count_in(count_in), .cond_ack(cond_ack), .taken(taken),
    .count_out(count_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic            tk;
    logic [BITS-1:0] cnt;
  } res_t;

  res_t q[$];

  // Reference state: architectural flags kept as named booleans
  logic            fx, fn, fz, fv, fc;
  logic            m_tk;
  logic [BITS-1:0] m_cnt;
  logic            started = 1'b0;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic cond_holds(input logic [3:0] cc);
    case (cc)
      4'h0: return 1'b1;
      4'h1: return 1'b0;
      4'h2: return !fc && !fz;
      4'h3: return fc || fz;
      4'h4: return !fc;
      4'h5: return fc;
      4'h6: return !fz;
      4'h7: return fz;
      4'h8: return !fv;
      4'h9: return fv;
      4'hA: return !fn;
      4'hB: return fn;
      4'hC: return fn == fv;
      4'hD: return fn != fv;
      4'hE: return !fz && (fn == fv);
      default: return fz || (fn != fv);
    endcase
  endfunction

  function automatic logic [4:0] model_ccr();
    return {fx, fn, fz, fv, fc};
  endfunction

  // One clock edge: the model reacts to the inputs present at the edge.
  task automatic tick();
    res_t r;
    int   nxt;
    @(posedge clk);
    if (reset) begin
      {fx, fn, fz, fv, fc} = 5'b0;
      m_tk  = 1'b0;
      m_cnt = '0;
    end else begin
      if (cond_req) begin
        if (!dbcc) begin
          r.tk  = cond_holds(cond);
          r.cnt = count_in;
        end else if (cond_holds(cond)) begin
          r.tk  = 1'b0;
          r.cnt = count_in;
        end else begin
          nxt   = int'(count_in) - 1;
          if (nxt < 0) nxt = (1 << BITS) - 1;
          r.cnt = nxt[BITS-1:0];
          r.tk  = (count_in != 0);
        end
        q.push_back(r);
        m_tk  = r.tk;
        m_cnt = r.cnt;
      end
      if (ccr_load) begin
        {fx, fn, fz, fv, fc} = ccr_in;
      end else if (flag_we) begin
        if (flag_mask[4]) fx = c;
        if (flag_mask[3]) fn = n;
        if (flag_mask[2]) fz = z;
        if (flag_mask[1]) fv = v;
        if (flag_mask[0]) fc = c;
      end
    end
    #1;
  endtask

  task automatic idle();
    reset = 0; flag_we = 0; flag_mask = 0; {c, z, v, n} = 4'b0;
    ccr_load = 0; ccr_in = 0; cond_req = 0; cond = 0; dbcc = 0; count_in = 0;
  endtask

  task automatic load(input logic [4:0] val);
    idle();
    ccr_load = 1; ccr_in = val;
    tick();
    idle();
  endtask

  task automatic req(input logic [3:0] cc, input logic db, input logic [BITS-1:0] cnt);
    idle();
    cond_req = 1; cond = cc; dbcc = db; count_in = cnt;
    tick();
    idle();
  endtask

  // Monitor: compares whatever the DUT presents against the scoreboard.
  always @(negedge clk) begin
    res_t r;
    if (started) begin
      chk("cond_ack", {31'b0, cond_ack}, {31'b0, q.size() != 0});
      if (q.size() != 0) begin
        r = q.pop_front();
        if (cond_ack) begin
          chk("taken", {31'b0, taken}, {31'b0, r.tk});
          chk("count_out", {16'b0, count_out}, {16'b0, r.cnt});
        end
      end
      chk("ccr", {27'b0, ccr}, {27'b0, model_ccr()});
      chk("taken_hold", {31'b0, taken}, {31'b0, m_tk});
      chk("count_hold", {16'b0, count_out}, {16'b0, m_cnt});
    end
  end

  initial begin
    idle();
    reset = 1;
    tick();
    tick();
    started = 1'b1;
    idle();
    @(negedge clk); #1;
    chk("reset_ccr", {27'b0, ccr}, 32'h0);
    chk("reset_ack", {31'b0, cond_ack}, 32'h0);

    // ALU flag latch with full mask
    flag_we = 1; flag_mask = 5'b11111; c = 1; z = 0; v = 0; n = 1;
    tick();
    idle();
    @(negedge clk); #1;
    chk("flag_we_all", {27'b0, ccr}, 32'h19);

    // LT / GE with N=1, V=0
    load(5'b01000);
    req(4'hD, 1'b0, 16'h1234);
    req(4'hC, 1'b0, 16'h0042);
    tick();

    // DBcc with false condition, then the zero-count wrap
    req(4'h1, 1'b1, 16'h0005);
    req(4'h1, 1'b1, 16'h0000);
    tick();

    // DBcc with true condition
    load(5'b00100);
    req(4'h7, 1'b1, 16'h0003);
    tick();

    // Same-edge load + flag_we + request: request sees the prior CCR
    load(5'b00000);
    ccr_load = 1; ccr_in = 5'b00100;
    flag_we = 1; flag_mask = 5'b11111; {c, z, v, n} = 4'b1111;
    cond_req = 1; cond = 4'h7; count_in = 16'h00AA;
    tick();
    idle();
    tick();

    // Masked update of V alone
    load(5'b00000);
    flag_we = 1; flag_mask = 5'b00010; {c, z, v, n} = 4'b1111;
    tick();
    idle();

    // Request on a reset edge is discarded
    reset = 1; cond_req = 1; cond = 4'h0; count_in = 16'h0007;
    tick();
    idle();
    tick();

    // Pending result followed by reset on the next edge
    req(4'h0, 1'b0, 16'h0011);
    reset = 1;
    tick();
    idle();
    tick();

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      reset     = ($urandom_range(0, 31) == 0);
      flag_we   = $urandom_range(0, 1);
      flag_mask = 5'($urandom);
      {c, z, v, n} = 4'($urandom);
      ccr_load  = ($urandom_range(0, 5) == 0);
      ccr_in    = 5'($urandom);
      cond_req  = ($urandom_range(0, 3) != 0);
      cond      = 4'($urandom);
      dbcc      = $urandom_range(0, 1);
      case ($urandom_range(0, 3))
        0: count_in = '0;
        1: count_in = 16'h0001;
        2: count_in = '1;
        default: count_in = 16'($urandom);
      endcase
      tick();
    end

    idle();
    tick();
    tick();
    @(negedge clk); #1;
    chk("queue_drained", q.size(), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
